// File: rtl/stoch_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : stoch_to_bin
// Purpose  : Converts the stochastic multiplier's bitstream back to binary by
//            counting ones across a frame of FRAME_WORDS input words. The
//            finished count is offered on a valid/ready output; the input is
//            back-pressured while a result is waiting to be taken.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            in_data/in_valid  - stochastic word from the multiplier
//            in_ready          - word is accepted this cycle
//            out_value         - ones count of the last completed frame
//            out_valid         - out_value holds a completed result
//            out_ready         - consumer takes out_value
//            busy              - partial frame accumulated or result held
// Revision : 1.0 - initial release
// ============================================================================
module stoch_to_bin #(
  parameter int SAMPLES     = 1,
  parameter int OSF         = 8,
  parameter int FRAME_WORDS = 32,
  parameter int CNT_W       = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SAMPLES*OSF-1:0]   in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [CNT_W-1:0]         out_value,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int c_in_w = SAMPLES * OSF;
  // Word counter needs at least one bit even for single-word frames.
  localparam int c_wc_w = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [c_wc_w-1:0] c_last_word = c_wc_w'(FRAME_WORDS - 1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_acc;
  logic [c_wc_w-1:0]   r_word_cnt;
  logic [CNT_W-1:0]    r_out_value;
  logic [CNT_W-1:0]    w_popcnt;
  logic [CNT_W-1:0]    w_sum;
  logic                w_accept;
  logic                w_last;

  // Ones count across the whole input word.
  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < c_in_w; i++) begin
      w_popcnt = w_popcnt + CNT_W'(in_data[i]);
    end
  end

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_word_cnt == c_last_word);
  assign w_sum    = r_acc + w_popcnt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        // Gated by rst so nothing is offered as accepted during reset.
        in_ready = !rst;
        if (w_accept && w_last) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_ACCUM;
        end
      end
      default: begin
        w_state_nxt = ST_ACCUM;
      end
    endcase
  end

  // Accumulator, frame position and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_word_cnt  <= '0;
      r_out_value <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        // Final word of the frame goes straight into the result so the
        // count is visible the cycle after it is accepted.
        r_out_value <= w_sum;
        r_acc       <= '0;
        r_word_cnt  <= '0;
      end else begin
        r_acc       <= w_sum;
        r_word_cnt  <= r_word_cnt + c_wc_w'(1);
      end
    end
  end

  assign out_value = r_out_value;
  assign busy      = (r_word_cnt != '0) || (r_state == ST_HOLD);

endmodule
`default_nettype wire

// File: doc/stoch_to_bin.md
Name: stoch_to_bin

Overview:
Downstream stage of the stochastic multiplier. It consumes the multiplier's SAMPLES*OSF-bit output words and counts the ones over a frame of FRAME_WORDS words, which turns the bitstream product back into a binary magnitude. The result is presented on a valid/ready output and the input side is back-pressured while a result is held.

Parameters:
SAMPLES, 1, samples per input word; must match the multiplier.
OSF, 8, oversampling factor (bits per sample); must match the multiplier.
FRAME_WORDS, 32, input words accumulated per conversion; must be >= 1.
CNT_W, 9, result width; must be >= clog2(SAMPLES*OSF*FRAME_WORDS + 1).

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
in_data  input  SAMPLES*OSF  stochastic word (multiplier output C).
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  block accepts in_data this cycle.
out_value  output  CNT_W  count of ones over the last completed frame.
out_valid  output  1  out_value holds a completed result.
out_ready  input  1  consumer accepts out_value.
busy  output  1  a frame is partially accumulated (word_cnt != 0) or a result is held.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Internal state: state in {ACCUM, HOLD}; acc[CNT_W-1:0]; word_cnt counting 0..FRAME_WORDS-1.
- Reset (rst=1 sampled at a clock edge): state=ACCUM, acc=0, word_cnt=0, out_value=0, out_valid=0.
- in_ready = (state==ACCUM) && !rst. This is combinational and has no dependence on in_valid.
- out_valid is 1 exactly when state==HOLD.
- Accept: in_valid && in_ready at a clock edge.
- popcount(in_data) is the number of 1 bits across the full word, zero-extended to CNT_W.
- ACCUM, accept with word_cnt < FRAME_WORDS-1:
  - acc <= acc + popcount
  - word_cnt <= word_cnt + 1
- ACCUM, accept with word_cnt == FRAME_WORDS-1:
  - out_value <= acc + popcount
  - out_valid <= 1
  - acc <= 0, word_cnt <= 0
  - state <= HOLD
- ACCUM, no accept (in_valid=0): all state holds. Gaps in in_valid are allowed anywhere in a frame.
- HOLD:
  - in_ready=0; input words offered are not consumed.
  - out_value and out_valid stay stable until out_valid && out_ready at an edge.
  - On that edge: out_valid <= 0, state <= ACCUM, and in_ready=1 on the next cycle.
  - out_value keeps its last value after the handshake; it is only meaningful while out_valid=1.
- Latency: result appears on the edge that accepts the last word of the frame, so it is visible in the following cycle. Minimum frame throughput is FRAME_WORDS+1 cycles (one bubble for the HOLD handshake).
- FRAME_WORDS=1: every accepted word produces a result directly.
- Arithmetic: addition is unsigned. No overflow can occur when CNT_W meets its constraint; behaviour with an undersized CNT_W is not specified.
- Reset mid-frame or in HOLD: the partial frame and any held result are discarded. No out_valid pulse is produced.
- out_ready asserted while out_valid=0 has no effect.

Test Plan:
Common config: SAMPLES=1, OSF=8, FRAME_WORDS=4, CNT_W=6.
1. After reset, feed 0xFF x4 back-to-back with out_ready=1 -> out_valid=1 for one cycle with out_value=32, in_ready=0 that cycle, back to 1 on the next.
2. Feed 0x01, 0x03, 0x07, 0x0F -> out_value=10. Then 0x00 x4 -> out_value=0.
3. Feed 0x0F x4 with out_ready=0 for 5 cycles -> out_valid held at 1, out_value=16 stable, in_ready=0, offered word 0xFF not consumed. Then raise out_ready -> handshake. The next frame starts with 0xFF counted first (total for 0xFF,0x00,0x00,0x00 = 8).
4. in_valid pattern 1,0,0,1,0,1,1 carrying 0x80, 0x81, 0xC0, 0x01 -> out_value=6, with out_valid rising only after the 4th accepted word.
5. Feed 0xFF x2, assert rst one cycle, then feed 0x01 x4 -> no result from the aborted frame; out_value=4; busy=0 directly after reset.
6. FRAME_WORDS=1, CNT_W=4: feed 0xAA, 0x3C with out_ready=1 -> two results: 4, then 4 on consecutive accepts separated by one HOLD cycle.
